// File: rtl/hs_pkg.sv
// hs_pkg: state encoding and helpers shared by the valid/ready handshake stages.
package hs_pkg;

    localparam int STATE_BITS = 1;

    typedef enum logic [STATE_BITS-1:0] {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/hs_serializer.sv
// hs_serializer: ready/valid width-down converter, one wide word out as BEATS
// registered narrow beats with last flag and beat index.
module hs_serializer
    import hs_pkg::*;
#(
    parameter int BEAT_WIDTH = 8,
    parameter int BEATS      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    localparam int IW        = (clog2(BEATS) > 1) ? clog2(BEATS) : 1
) (
    input  logic                        clock,
    input  logic                        clear_n,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic [BEAT_WIDTH*BEATS-1:0] input_data,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [BEAT_WIDTH-1:0]       output_data,
    output logic                        output_last,
    output logic [IW-1:0]               output_index
);

    localparam int DW = BEAT_WIDTH * BEATS;

    state_t          state_q, state_d;
    logic [DW-1:0]   sr_q, sr_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            insert, remove;

    assign output_valid = (state_q == BUSY);
    assign remove       = output_valid & output_ready;
    // Combinational ready path lets the next word load on the last beat's handshake.
    assign input_ready  = (state_q != BUSY) | (remove & last_q);
    assign insert       = input_valid & input_ready;
    assign output_data  = LSB_FIRST ? sr_q[BEAT_WIDTH-1:0] : sr_q[DW-1 -: BEAT_WIDTH];
    assign output_last  = last_q;
    assign output_index = cnt_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (insert) begin
            state_d = BUSY;
            sr_d    = input_data;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (remove) begin
            if (last_q) begin
                state_d = EMPTY;
            end else begin
                sr_d   = LSB_FIRST ? (sr_q >> BEAT_WIDTH) : (sr_q << BEAT_WIDTH);
                cnt_d  = cnt_q + 1'b1;
                last_d = ((cnt_q + 1'b1) == IW'(BEATS - 1));
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= EMPTY;
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_hs_serializer.sv
// tb_hs_serializer: directed checks of the serializer in LSB-first and MSB-first builds.
module tb_hs_serializer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        iv, ir, ov, ordy, ol;
    logic [31:0] id;
    logic [7:0]  od;
    logic [1:0]  oi;
    logic        m_iv, m_ir, m_ov, m_ordy, m_ol;
    logic [31:0] m_id;
    logic [7:0]  m_od;
    logic [1:0]  m_oi;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    hs_serializer #(.BEAT_WIDTH(8), .BEATS(4), .LSB_FIRST(1'b1)) u_lsb (
        .clock(clock), .clear_n(clear_n),
        .input_valid(iv), .input_ready(ir), .input_data(id),
        .output_valid(ov), .output_ready(ordy), .output_data(od),
        .output_last(ol), .output_index(oi)
    );

    hs_serializer #(.BEAT_WIDTH(8), .BEATS(4), .LSB_FIRST(1'b0)) u_msb (
        .clock(clock), .clear_n(clear_n),
        .input_valid(m_iv), .input_ready(m_ir), .input_data(m_id),
        .output_valid(m_ov), .output_ready(m_ordy), .output_data(m_od),
        .output_last(m_ol), .output_index(m_oi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input string tag, input bit msb, input logic [7:0] d,
                        input int idx, input bit last, input bit rdy);
        check({tag, ".valid"}, msb ? m_ov : ov, 1);
        check({tag, ".data"},  msb ? m_od : od, d);
        check({tag, ".index"}, msb ? m_oi : oi, idx);
        check({tag, ".last"},  msb ? m_ol : ol, last);
        check({tag, ".ready"}, msb ? m_ir : ir, rdy);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] b2b [8];
        b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_n = 1'b0; iv = 1'b1; id = 32'hDDCCBBAA; ordy = 1'b1;
        m_iv = 1'b0; m_id = 32'h0; m_ordy = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        check("rst.valid", ov, 0);
        check("rst.data",  od, 0);
        check("rst.last",  ol, 0);
        check("rst.index", oi, 0);
        check("rst.ready", ir, 1);
        @(negedge clock) clear_n = 1'b1;
        // single word, accepted on the first edge after release
        cyc(); iv = 1'b0; #1;
        beat("single0", 0, 8'hAA, 0, 0, 0);
        cyc(); #1; beat("single1", 0, 8'hBB, 1, 0, 0);
        cyc(); #1; beat("single2", 0, 8'hCC, 2, 0, 0);
        cyc(); #1; beat("single3", 0, 8'hDD, 3, 1, 1);
        cyc(); iv = 1'b1; id = 32'h44332211; #1;
        check("idle.valid", ov, 0);
        // back-to-back words with no bubble
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) id = 32'h88776655;
            if (i == 4) iv = 1'b0;
            #1;
            beat($sformatf("b2b%0d", i), 0, b2b[i], i % 4, (i % 4) == 3, (i % 4) == 3);
        end
        cyc(); iv = 1'b1; id = 32'hDDCCBBAA; #1;
        check("idle2.valid", ov, 0);
        // backpressure on beat BB
        cyc(); iv = 1'b0; #1; beat("bp0", 0, 8'hAA, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); ordy = 1'b0; #1;
            beat($sformatf("bp_hold%0d", i), 0, 8'hBB, 1, 0, 0);
        end
        cyc(); ordy = 1'b1; #1; beat("bp1", 0, 8'hBB, 1, 0, 0);
        cyc(); #1; beat("bp2", 0, 8'hCC, 2, 0, 0);
        cyc(); #1; beat("bp3", 0, 8'hDD, 3, 1, 1);
        cyc(); iv = 1'b1; id = 32'hDDCCBBAA; #1;
        // reset mid-word after BB has been removed
        cyc(); iv = 1'b0; #1; beat("mid0", 0, 8'hAA, 0, 0, 0);
        cyc(); #1; beat("mid1", 0, 8'hBB, 1, 0, 0);
        cyc(); #1; beat("mid2", 0, 8'hCC, 2, 0, 0);
        clear_n = 1'b0; #1;
        check("midrst.valid", ov, 0);
        check("midrst.index", oi, 0);
        check("midrst.last",  ol, 0);
        iv = 1'b1; id = 32'h04030201;
        @(negedge clock) clear_n = 1'b1;
        cyc(); iv = 1'b0; #1; beat("post0", 0, 8'h01, 0, 0, 0);
        cyc(); #1; beat("post1", 0, 8'h02, 1, 0, 0);
        cyc(); #1; beat("post2", 0, 8'h03, 2, 0, 0);
        cyc(); #1; beat("post3", 0, 8'h04, 3, 1, 1);
        // MSB-first build
        m_iv = 1'b1; m_id = 32'hDDCCBBAA;
        cyc(); m_iv = 1'b0; #1; beat("msb0", 1, 8'hDD, 0, 0, 0);
        cyc(); #1; beat("msb1", 1, 8'hCC, 1, 0, 0);
        cyc(); #1; beat("msb2", 1, 8'hBB, 2, 0, 0);
        cyc(); #1; beat("msb3", 1, 8'hAA, 3, 1, 1);
        cyc(); #1;
        check("msb_idle.valid", m_ov, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
